// File: rtl/adc_scan_sequencer.sv
`timescale 1ns/1ps
// adc_scan_sequencer: round-robin conversion scheduler for the LTC2308 interface
// block. Walks the enabled channels, issues a start pulse per channel, waits
// for the conversion-done flag and keeps the latest 12-bit result per channel.
module adc_scan_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int GUARD_CYCLES   = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        scan_enable,
   input  logic        oneshot,
   input  logic [7:0]  ch_mask,
   output logic        adc_start,
   output logic [2:0]  adc_ch,
   input  logic        adc_done,
   input  logic [11:0] adc_data,
   input  logic [2:0]  rd_ch,
   output logic [11:0] rd_data,
   output logic [7:0]  result_valid,
   output logic        sample_strobe,
   output logic [2:0]  sample_ch,
   output logic [11:0] sample_data,
   output logic        scan_busy,
   output logic        pass_done,
   output logic        timeout_err,
   input  logic        clear_err
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GUARD_LAST   = GW'(GUARD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      START,
      GUARD,
      WAIT,
      STORE
   } state_t;

   state_t         state_q, state_d;
   logic           oneshotMode_q, oneshotMode_d;
   logic [7:0]     passMask_q, passMask_d;
   logic [2:0]     lastCh_q, lastCh_d;
   logic [2:0]     adcCh_q, adcCh_d;
   logic [GW-1:0]  guardCnt_q, guardCnt_d;
   logic [TW-1:0]  timeoutCnt_q, timeoutCnt_d;
   logic           timeoutErr_q, timeoutErr_d;
   logic           passDone_q, passDone_d;
   logic [11:0]    result_q [8];
   logic [7:0]     resultValid_q;

   logic [7:0]     scanMask;
   logic [7:0]     passAfter;
   logic [2:0]     candCh;
   logic           candFound;
   logic           convDone;

   // Find the first enabled channel after the last one, wrapping 7 -> 0; the
   // eighth candidate is the last channel itself, so a lone channel repeats.
   always_comb begin
      scanMask  = oneshotMode_q ? passMask_q : ch_mask;
      candFound = 1'b0;
      candCh    = lastCh_q;
      for (int i = 1; i <= 8; i++) begin
         if (!candFound && scanMask[3'(int'(lastCh_q) + i)]) begin
            candFound = 1'b1;
            candCh    = 3'(int'(lastCh_q) + i);
         end
      end
   end

   // Next-state logic; a finished conversion (stored or abandoned) funnels
   // through one shared decision about whether to keep scanning.
   always_comb begin
      state_d       = state_q;
      oneshotMode_d = oneshotMode_q;
      passMask_d    = passMask_q;
      lastCh_d      = lastCh_q;
      adcCh_d       = adcCh_q;
      guardCnt_d    = guardCnt_q;
      timeoutCnt_d  = timeoutCnt_q;
      timeoutErr_d  = timeoutErr_q & ~clear_err;
      passDone_d    = 1'b0;
      convDone      = 1'b0;
      passAfter     = passMask_q & ~(8'b1 << adcCh_q);
      case (state_q)
         IDLE: begin
            if (scan_enable && |ch_mask) begin
               state_d       = SELECT;
               oneshotMode_d = 1'b0;
            end else if (oneshot && |ch_mask) begin
               state_d       = SELECT;
               oneshotMode_d = 1'b1;
               passMask_d    = ch_mask;
            end
         end
         SELECT: begin
            if (candFound) begin
               adcCh_d  = candCh;
               lastCh_d = candCh;
               state_d  = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            guardCnt_d = '0;
            state_d    = GUARD;
         end
         GUARD: begin
            if (guardCnt_q == GUARD_LAST) begin
               timeoutCnt_d = '0;
               state_d      = WAIT;
            end else begin
               guardCnt_d = guardCnt_q + 1'b1;
            end
         end
         WAIT: begin
            if (adc_done) begin
               state_d = STORE;
            end else if (timeoutCnt_q == TIMEOUT_LAST) begin
               timeoutErr_d = 1'b1;
               convDone     = 1'b1;
            end else begin
               timeoutCnt_d = timeoutCnt_q + 1'b1;
            end
         end
         STORE: begin
            convDone = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (convDone) begin
         if (oneshotMode_q) begin
            passMask_d = passAfter;
            if (passAfter == 8'h00) begin
               passDone_d = 1'b1;
               state_d    = IDLE;
            end else begin
               state_d = SELECT;
            end
         end else if (scan_enable && |ch_mask) begin
            state_d = SELECT;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         oneshotMode_q <= 1'b0;
         passMask_q    <= 8'h00;
         lastCh_q      <= 3'd7;
         adcCh_q       <= 3'd0;
         guardCnt_q    <= '0;
         timeoutCnt_q  <= '0;
         timeoutErr_q  <= 1'b0;
         passDone_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         oneshotMode_q <= oneshotMode_d;
         passMask_q    <= passMask_d;
         lastCh_q      <= lastCh_d;
         adcCh_q       <= adcCh_d;
         guardCnt_q    <= guardCnt_d;
         timeoutCnt_q  <= timeoutCnt_d;
         timeoutErr_q  <= timeoutErr_d;
         passDone_q    <= passDone_d;
      end
   end

   // Result bank: captures the converter output while in STORE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            result_q[i] <= 12'h000;
         end
         resultValid_q <= 8'h00;
      end else if (state_q == STORE) begin
         result_q[adcCh_q]      <= adc_data;
         resultValid_q[adcCh_q] <= 1'b1;
      end
   end

   assign adc_start     = (state_q == START);
   assign adc_ch        = adcCh_q;
   assign sample_strobe = (state_q == STORE);
   assign sample_ch     = adcCh_q;
   assign sample_data   = (state_q == STORE) ? adc_data : 12'h000;
   assign scan_busy     = (state_q != IDLE);
   assign pass_done     = passDone_q;
   assign timeout_err   = timeoutErr_q;
   assign rd_data       = result_q[rd_ch];
   assign result_valid  = resultValid_q;

endmodule
